// File: rtl/lock_code_sender_if.sv
// Code-entry link between the requesting logic and the lock-code transmitter.
// The master starts a sequence; the slave drives the lock pins and status.
interface lock_code_sender_if #(
    parameter int CODE_LEN = 7
);
    logic                start;
    logic [CODE_LEN-1:0] code;
    logic                x;
    logic                enter;
    logic                reset_lock;
    logic                busy;
    logic                done;

    modport master (
        output start, code,
        input  x, enter, reset_lock, busy, done
    );

    modport slave (
        input  start, code,
        output x, enter, reset_lock, busy, done
    );
endinterface

// File: rtl/lock_code_sender.sv
// Shifts a parallel code out MSB-first to the lock, one bit per active-low Enter
// strobe, optionally preceded by one clear strobe with Reset_Lock low.
module lock_code_sender #(
    parameter int CODE_LEN  = 7,
    parameter int SETUP_CYC = 4,
    parameter int LOW_CYC   = 8,
    parameter int HIGH_CYC  = 8,
    parameter bit CLEAR_EN  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    lock_code_sender_if.slave    bus
);

    localparam int MAX_LH  = (LOW_CYC > HIGH_CYC) ? LOW_CYC : HIGH_CYC;
    localparam int MAX_CYC = (SETUP_CYC > MAX_LH) ? SETUP_CYC : MAX_LH;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int IDX_W   = $clog2(CODE_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR_SETUP,
        CLR_STROBE,
        CLR_HOLD,
        BIT_SETUP,
        BIT_STROBE,
        BIT_HOLD,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_LEN-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                x_q, x_d;
    logic                enter_q, enter_d;
    logic                rl_q, rl_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                phase_end;

    // Counter load for a state: it counts down to zero, so load length-1.
    function automatic logic [CNT_W-1:0] phase_len(input state_t s);
        case (s)
            CLR_SETUP, BIT_SETUP:   phase_len = CNT_W'(SETUP_CYC - 1);
            CLR_STROBE, BIT_STROBE: phase_len = CNT_W'(LOW_CYC - 1);
            CLR_HOLD, BIT_HOLD:     phase_len = CNT_W'(HIGH_CYC - 1);
            default:                phase_len = '0;
        endcase
    endfunction

    // State and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            x_q     <= 1'b0;
            enter_q <= 1'b1;
            rl_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            enter_q <= enter_d;
            rl_q    <= rl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign phase_end = (cnt_q == '0);

    // Next state, phase counter and shift register.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    shift_d = bus.code;
                    idx_d   = '0;
                    state_d = CLEAR_EN ? CLR_SETUP : BIT_SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            CLR_SETUP:  if (phase_end) state_d = CLR_STROBE;
            CLR_STROBE: if (phase_end) state_d = CLR_HOLD;
            CLR_HOLD:   if (phase_end) state_d = BIT_SETUP;
            BIT_SETUP:  if (phase_end) state_d = BIT_STROBE;
            BIT_STROBE: if (phase_end) state_d = BIT_HOLD;
            BIT_HOLD: begin
                if (phase_end) begin
                    shift_d = shift_q << 1;
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = (idx_q == IDX_W'(CODE_LEN - 1)) ? DONE : BIT_SETUP;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = phase_len(state_d);
        end else if (!phase_end) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outputs are decoded from the upcoming state so they land in flops.
    always_comb begin
        x_d     = 1'b0;
        enter_d = 1'b1;
        rl_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_d)
            CLR_SETUP: begin
                rl_d   = 1'b0;
                busy_d = 1'b1;
            end
            CLR_STROBE: begin
                rl_d    = 1'b0;
                enter_d = 1'b0;
                busy_d  = 1'b1;
            end
            CLR_HOLD: begin
                busy_d = 1'b1;
            end
            BIT_SETUP, BIT_HOLD: begin
                x_d    = shift_d[CODE_LEN-1];
                busy_d = 1'b1;
            end
            BIT_STROBE: begin
                x_d     = shift_d[CODE_LEN-1];
                enter_d = 1'b0;
                busy_d  = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.x          = x_q;
    assign bus.enter      = enter_q;
    assign bus.reset_lock = rl_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_lock_code_sender.sv
// Randomized bench for lock_code_sender: two configurations checked cycle by
// cycle against an expected-waveform model plus timing-invariant monitors.
module tb_lock_code_sender;

    localparam int A_LEN = 7, A_SETUP = 4, A_LOW = 8, A_HIGH = 8;
    localparam bit A_CLR = 1'b1;
    localparam int B_LEN = 3, B_SETUP = 1, B_LOW = 1, B_HIGH = 1;
    localparam bit B_CLR = 1'b0;

    // {busy, done, x, enter, reset_lock}
    typedef logic [4:0] vec_t;
    localparam vec_t IDLE_V = 5'b00011;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lock_code_sender_if #(.CODE_LEN(A_LEN)) bus_a ();
    lock_code_sender_if #(.CODE_LEN(B_LEN)) bus_b ();

    lock_code_sender #(
        .CODE_LEN(A_LEN), .SETUP_CYC(A_SETUP), .LOW_CYC(A_LOW),
        .HIGH_CYC(A_HIGH), .CLEAR_EN(A_CLR)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    lock_code_sender #(
        .CODE_LEN(B_LEN), .SETUP_CYC(B_SETUP), .LOW_CYC(B_LOW),
        .HIGH_CYC(B_HIGH), .CLEAR_EN(B_CLR)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Expected waveform of one full sequence, from the accept edge onward.
    task automatic build(input logic [31:0] code, input int len, input int setup,
                         input int low, input int high, input bit clr, output vec_t seq[$]);
        int   n_strobe;
        bit   is_clr;
        logic xv;
        seq = {};
        n_strobe = len + (clr ? 1 : 0);
        for (int s = 0; s < n_strobe; s++) begin
            is_clr = clr && (s == 0);
            xv = is_clr ? 1'b0 : code[len - 1 - (s - (clr ? 1 : 0))];
            for (int i = 0; i < setup; i++) seq.push_back({1'b1, 1'b0, xv, 1'b1, ~is_clr});
            for (int i = 0; i < low;   i++) seq.push_back({1'b1, 1'b0, xv, 1'b0, ~is_clr});
            for (int i = 0; i < high;  i++) seq.push_back({1'b1, 1'b0, xv, 1'b1, 1'b1});
        end
        seq.push_back(5'b01011);
    endtask

    vec_t qa[$], qb[$];
    vec_t exp_a, exp_b;
    logic xa_p, rla_p, ena_p, xb_p, rlb_p, enb_p;
    int   st_a, st_b;

    wire vec_t vec_a = {bus_a.busy, bus_a.done, bus_a.x, bus_a.enter, bus_a.reset_lock};
    wire vec_t vec_b = {bus_b.busy, bus_b.done, bus_b.x, bus_b.enter, bus_b.reset_lock};

    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
            check("a_reset_out", 32'(vec_a), 32'(IDLE_V));
            st_a = 0;
        end else begin
            if (qa.size() != 0) exp_a = qa.pop_front();
            else exp_a = IDLE_V;
            check("a_out", 32'(vec_a), 32'(exp_a));
            if (bus_a.x !== xa_p || bus_a.reset_lock !== rla_p) begin
                check("a_change_while_enter_low", 32'(bus_a.enter), 32'(1));
                st_a = 1;
            end else begin
                st_a++;
            end
            if (ena_p && !bus_a.enter) check("a_setup_before_fall", 32'(st_a > A_SETUP), 32'(1));
        end
        xa_p = bus_a.x; rla_p = bus_a.reset_lock; ena_p = bus_a.enter;
    end

    always @(negedge clk) begin
        if (rst) begin
            qb.delete();
            check("b_reset_out", 32'(vec_b), 32'(IDLE_V));
            st_b = 0;
        end else begin
            if (qb.size() != 0) exp_b = qb.pop_front();
            else exp_b = IDLE_V;
            check("b_out", 32'(vec_b), 32'(exp_b));
            if (bus_b.x !== xb_p || bus_b.reset_lock !== rlb_p) begin
                check("b_change_while_enter_low", 32'(bus_b.enter), 32'(1));
                st_b = 1;
            end else begin
                st_b++;
            end
            if (enb_p && !bus_b.enter) check("b_setup_before_fall", 32'(st_b > B_SETUP), 32'(1));
        end
        xb_p = bus_b.x; rlb_p = bus_b.reset_lock; enb_p = bus_b.enter;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_a(input logic [A_LEN-1:0] c);
        vec_t seq[$];
        bus_a.code  = c;
        bus_a.start = 1'b1;
        build(32'(c), A_LEN, A_SETUP, A_LOW, A_HIGH, A_CLR, seq);
        foreach (seq[i]) qa.push_back(seq[i]);
    endtask

    task automatic start_b(input logic [B_LEN-1:0] c);
        vec_t seq[$];
        bus_b.code  = c;
        bus_b.start = 1'b1;
        build(32'(c), B_LEN, B_SETUP, B_LOW, B_HIGH, B_CLR, seq);
        foreach (seq[i]) qb.push_back(seq[i]);
    endtask

    // Runs until the queued waveform is consumed; ends right after the Done sample.
    task automatic drain_a(input string tag, input bit poke);
        int n = 0;
        while (qa.size() != 0 && n < 1000) begin
            if (poke && qa.size() > 3 && $urandom_range(0, 15) == 0) begin
                bus_a.start = 1'b1;
                bus_a.code  = A_LEN'($urandom);
            end else begin
                bus_a.start = 1'b0;
            end
            tick();
            n++;
        end
        bus_a.start = 1'b0;
        check(tag, 32'(n < 1000), 32'(1));
    endtask

    task automatic drain_b(input string tag);
        int n = 0;
        while (qb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 200), 32'(1));
    endtask

    initial begin
        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.code = '0;
        bus_b.start = 1'b0; bus_b.code = '0;
        #2;
        check("a_reset_state", 32'(vec_a), 32'(IDLE_V));
        check("b_reset_state", 32'(vec_b), 32'(IDLE_V));
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Default code, single pulse.
        start_a(7'b1110111);
        tick();
        bus_a.start = 1'b0;
        drain_a("a_seq1_timeout", 1'b0);
        repeat (3) tick();

        // Start held for 50 cycles, code scrambled after acceptance.
        start_a(7'b1110111);
        for (int i = 1; i < 50; i++) begin
            tick();
            if (i == 10) bus_a.code = 7'b0000000;
        end
        bus_a.start = 1'b0;
        drain_a("a_held_timeout", 1'b0);
        repeat (2) tick();

        // Back-to-back: second Start lands in the Done cycle.
        start_a(7'($urandom));
        tick();
        bus_a.start = 1'b0;
        drain_a("a_b2b_first_timeout", 1'b0);
        start_a(7'b0101010);
        tick();
        bus_a.start = 1'b0;
        drain_a("a_b2b_second_timeout", 1'b0);
        repeat (2) tick();

        // Reset during the third code-bit strobe (Enter low).
        start_a(7'b1110111);
        tick();
        bus_a.start = 1'b0;
        repeat (67) tick();
        check("a_enter_low_before_reset", 32'(bus_a.enter), 32'(0));
        rst = 1'b1;
        #1;
        check("a_async_reset_out", 32'(vec_a), 32'(IDLE_V));
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        start_a(7'b1110111);
        tick();
        bus_a.start = 1'b0;
        drain_a("a_after_reset_timeout", 1'b0);
        repeat (2) tick();

        // Random codes, random gaps, spurious Start pulses while busy.
        for (int k = 0; k < 4; k++) begin
            start_a(7'($urandom));
            tick();
            drain_a("a_rand_timeout", 1'b1);
            repeat ($urandom_range(0, 4)) tick();
        end
        repeat (2) tick();

        // Short configuration without the clear strobe.
        start_b(3'b101);
        tick();
        bus_b.start = 1'b0;
        drain_b("b_seq1_timeout");
        repeat (2) tick();
        for (int k = 0; k < 6; k++) begin
            start_b(3'($urandom));
            tick();
            bus_b.start = 1'b0;
            drain_b("b_rand_timeout");
            repeat ($urandom_range(0, 3)) tick();
        end
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lock_code_sender.md
Name: lock_code_sender

Overview:
- Transmitter side of the serial code-entry interface used by DigitalLockController. Drives X, Enter and Reset_Lock so a lock opens without a human at the switches.
- On Start, captures a parallel code. Optionally issues a lock/clear strobe, then shifts the code out MSB-first, one bit per active-low Enter strobe.
- Timing parameters guarantee X is stable around each falling Enter edge, where the receiver samples.
- Sits between the test/keypad logic and the lock receiver pins.

Parameters:
- CODE_LEN, 7, number of code bits sent per sequence (≥1).
- SETUP_CYC, 4, cycles X/Reset_Lock are held stable with Enter high before each falling edge (≥1).
- LOW_CYC, 8, cycles Enter is held low per strobe (≥1).
- HIGH_CYC, 8, cycles Enter is held high after each strobe (≥1).
- CLEAR_EN, 1, 1 = prepend one clear strobe with Reset_Lock low; 0 = send code bits only.

Ports:
- Clock  input  1  system clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request to send; sampled when Busy=0.
- Code  input  CODE_LEN  code to send; Code[CODE_LEN-1] is sent first.
- X  output  1  serial code bit to the lock.
- Enter  output  1  active-low strobe; the lock samples on its falling edge.
- Reset_Lock  output  1  active-low clear/lock request to the lock.
- Busy  output  1  high while a sequence is in progress.
- Done  output  1  one-cycle pulse when a sequence completes.

Behaviour:
- All outputs are registered, with no combinational path from inputs to outputs.
- Reset values: X=0, Enter=1, Reset_Lock=1, Busy=0, Done=0. FSM goes to IDLE and counters clear.
- States: IDLE, CLR_SETUP, CLR_STROBE, CLR_HOLD, BIT_SETUP, BIT_STROBE, BIT_HOLD, DONE.
- IDLE: outputs are at their reset values. Start=1 at a rising edge latches Code into a shift register and zeroes the bit index.
  - CLEAR_EN=1: next state is CLR_SETUP.
  - CLEAR_EN=0: next state is BIT_SETUP.
- Busy is 1 in every state except IDLE and DONE.
- CLR_SETUP (SETUP_CYC cycles): Reset_Lock=0, Enter=1, X=0.
- CLR_STROBE (LOW_CYC cycles): Reset_Lock=0, Enter=0.
- CLR_HOLD (HIGH_CYC cycles): Reset_Lock=1, Enter=1. Then BIT_SETUP.
- BIT_SETUP (SETUP_CYC cycles): Enter=1, X = current MSB of the shift register.
- BIT_STROBE (LOW_CYC cycles): Enter=0, X held.
- BIT_HOLD (HIGH_CYC cycles): Enter=1, X held.
  - At the end of BIT_HOLD, shift left and increment the bit index.
  - If CODE_LEN bits have been sent, go to DONE; otherwise go to BIT_SETUP.
- DONE (1 cycle): Done=1, Busy=0, X=0, Enter=1. Then IDLE.
  - Start=1 in the DONE cycle is accepted, giving back-to-back sequences.
- Invariants:
  - X changes only while Enter=1, and at least SETUP_CYC cycles before any falling edge of Enter.
  - Reset_Lock changes only while Enter=1.
- Latency: Start accepted at edge E0 → first Busy cycle follows E0.
  - Total busy cycles = (CODE_LEN+CLEAR_EN)*(SETUP_CYC+LOW_CYC+HIGH_CYC).
  - Done asserts in the cycle immediately after the last busy cycle.
  - Defaults: 8*20 = 160 busy cycles; Done in cycle 160, counting the first busy cycle as 0.
- Start while Busy=1 is ignored and not queued. Code changes after acceptance have no effect.
- Phase counter: single down-counter, width $clog2 of the largest of SETUP_CYC, LOW_CYC, HIGH_CYC, plus 1. Reloaded on every state entry.
- Reset asserted mid-sequence:
  - Outputs return to reset values asynchronously; Enter rising mid-strobe is permitted.
  - Latched code is discarded. No Done pulse.

Test Plan:
- Defaults, Code=7'b1110111, one Start pulse → 8 falling Enter edges.
  - Edge 1: Reset_Lock=0.
  - Edges 2–8: X = 1,1,1,0,1,1,1 with Reset_Lock=1.
  - Busy high for exactly 160 cycles; Done single pulse in cycle 160.
- Start held high for 50 cycles, with Code toggled to 7'b0000000 at cycle 10 → single sequence still sends 1110111; no restart until Done.
- Start asserted during the DONE cycle with Code=7'b0101010 → second sequence begins next cycle, no idle gap; X sequence 0,1,0,1,0,1,0.
- Reset pulsed during the third bit strobe, i.e. Enter=0 → Enter=1, Reset_Lock=1, X=0, Busy=0 immediately; no Done; next Start replays the full sequence from the clear strobe.
- CLEAR_EN=0, SETUP_CYC=1, LOW_CYC=1, HIGH_CYC=1, CODE_LEN=3, Code=3'b101 → 3 falling edges with X=1,0,1; Reset_Lock never low; Busy 9 cycles; Done in cycle 9.
- Checker over all runs: X and Reset_Lock never change while Enter=0; X stable ≥SETUP_CYC cycles before each falling Enter edge.
